// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit common-anode seven-segment driver. scan_in is sampled
// as a strobe in the clk domain; the display value is captured once per frame.
module seg7_scan_driver #(
    parameter bit BLANK_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scan_in,
    input  logic [31:0] value,
    input  logic [7:0]  digit_en,
    input  logic [7:0]  dp_in,
    input  logic        lz_en,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    logic [0:0]  state;
    logic [2:0]  idx;
    logic        scan_prev;
    logic [31:0] sh_value;
    logic [7:0]  sh_en;
    logic [7:0]  sh_dp;
    logic        sh_lz;

    logic        ev;
    logic        load;
    logic [2:0]  drive_idx;
    logic [31:0] cur_value;
    logic [7:0]  cur_en;
    logic [7:0]  cur_dp;
    logic        cur_lz;
    logic [7:0]  signif;
    logic [7:0]  visible;
    logic        any_above;
    logic [3:0]  nibble;

    function automatic logic [6:0] hex_decode(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // The digit being driven uses the freshly captured inputs on the frame-start event.
    always_comb begin
        ev        = scan_in & ~scan_prev;
        drive_idx = (state == ST_BLANK) ? idx : idx + 3'd1;
        load      = ev && (drive_idx == 3'd0) && ((state == ST_BLANK) || !BLANK_EN);
        cur_value = load ? value    : sh_value;
        cur_en    = load ? digit_en : sh_en;
        cur_dp    = load ? dp_in    : sh_dp;
        cur_lz    = load ? lz_en    : sh_lz;
        // NOTE: every combinational output gets a default first so no latch is inferred.
        signif    = '0;
        visible   = '0;
        any_above = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            signif[i]  = cur_en[i] && ((cur_value[4*i +: 4] != 4'h0) || cur_dp[i]);
            any_above  = any_above | signif[i];
            visible[i] = cur_en[i] && (!cur_lz || any_above || (i == 0));
        end
        nibble = cur_value[{drive_idx, 2'b00} +: 4];
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, avoiding ordering races.
        if (reset) begin
            state       <= ST_BLANK;
            idx         <= 3'd0;
            scan_prev   <= 1'b0;
            an          <= 8'hFF;
            seg         <= 7'h7F;
            dp          <= 1'b1;
            frame_start <= 1'b0;
            sh_value    <= '0;
            sh_en       <= '0;
            sh_dp       <= '0;
            sh_lz       <= 1'b0;
        end else begin
            scan_prev   <= scan_in;
            frame_start <= 1'b0;
            if (ev) begin
                if ((state == ST_SHOW) && BLANK_EN) begin
                    an    <= 8'hFF;
                    seg   <= 7'h7F;
                    dp    <= 1'b1;
                    idx   <= idx + 3'd1;
                    state <= ST_BLANK;
                end else begin
                    an          <= visible[drive_idx] ? ~(8'b1 << drive_idx) : 8'hFF;
                    seg         <= visible[drive_idx] ? hex_decode(nibble) : 7'h7F;
                    dp          <= visible[drive_idx] ? ~cur_dp[drive_idx] : 1'b1;
                    idx         <= drive_idx;
                    state       <= ST_SHOW;
                    frame_start <= load;
                    if (load) begin
                        sh_value <= value;
                        sh_en    <= digit_en;
                        sh_dp    <= dp_in;
                        sh_lz    <= lz_en;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench: runs a blanking and a back-to-back instance side by side
// against a frame-snapshot scoreboard driven from a table of display vectors.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        scan_in;
    logic [31:0] value;
    logic [7:0]  digit_en;
    logic [7:0]  dp_in;
    logic        lz_en;
    logic [7:0]  b_an, n_an;
    logic [6:0]  b_seg, n_seg;
    logic        b_dp, n_dp, b_fs, n_fs;

    seg7_scan_driver #(.BLANK_EN(1'b1)) dut_b (
        .clk(clk), .reset(reset), .scan_in(scan_in), .value(value),
        .digit_en(digit_en), .dp_in(dp_in), .lz_en(lz_en),
        .an(b_an), .seg(b_seg), .dp(b_dp), .frame_start(b_fs)
    );

    seg7_scan_driver #(.BLANK_EN(1'b0)) dut_n (
        .clk(clk), .reset(reset), .scan_in(scan_in), .value(value),
        .digit_en(digit_en), .dp_in(dp_in), .lz_en(lz_en),
        .an(n_an), .seg(n_seg), .dp(n_dp), .frame_start(n_fs)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
    } exp_t;

    typedef struct {
        logic [31:0] value;
        logic [7:0]  en;
        logic [7:0]  dpi;
        logic        lz;
        logic [7:0]  vis;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[7];
    logic [6:0]  hex_tbl[16];
    logic [7:0]  cur_vis;
    int          checks   = 0;
    int          failures = 0;
    int          k_b = 0;
    int          k_n = 0;
    logic [31:0] sb_value, sn_value;
    logic [7:0]  sb_vis, sn_vis, sb_dp, sn_dp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t digit_exp(input int i, input logic [31:0] v, input logic [7:0] vis,
                                       input logic [7:0] dpi, input logic fs);
        exp_t e;
        logic [3:0] nib;
        nib = v[4*i +: 4];
        if (vis[i]) begin
            e.an  = ~(8'b1 << i);
            e.seg = hex_tbl[nib];
            e.dp  = ~dpi[i];
        end else begin
            e.an  = 8'hFF;
            e.seg = 7'h7F;
            e.dp  = 1'b1;
        end
        e.fs = fs;
        return e;
    endfunction

    task automatic check_pair(input string tag, input exp_t eb, input exp_t en);
        check({tag, " b.an"},  {24'h0, b_an},  {24'h0, eb.an});
        check({tag, " b.seg"}, {25'h0, b_seg}, {25'h0, eb.seg});
        check({tag, " b.dp"},  {31'h0, b_dp},  {31'h0, eb.dp});
        check({tag, " b.fs"},  {31'h0, b_fs},  {31'h0, eb.fs});
        check({tag, " n.an"},  {24'h0, n_an},  {24'h0, en.an});
        check({tag, " n.seg"}, {25'h0, n_seg}, {25'h0, en.seg});
        check({tag, " n.dp"},  {31'h0, n_dp},  {31'h0, en.dp});
        check({tag, " n.fs"},  {31'h0, n_fs},  {31'h0, en.fs});
    endtask

    // One rising edge on scan_in; scan_in then stays high for 'hold' extra cycles.
    task automatic do_event(input int hold);
        exp_t eb, en, blank;
        blank.an = 8'hFF; blank.seg = 7'h7F; blank.dp = 1'b1; blank.fs = 1'b0;
        if (k_b == 0) begin
            sb_value = value; sb_vis = cur_vis; sb_dp = dp_in;
        end
        if (k_n == 0) begin
            sn_value = value; sn_vis = cur_vis; sn_dp = dp_in;
        end
        if (k_b % 2 == 0) sb.push_back(digit_exp(k_b / 2, sb_value, sb_vis, sb_dp, k_b == 0));
        else              sb.push_back(blank);
        sb.push_back(digit_exp(k_n, sn_value, sn_vis, sn_dp, k_n == 0));

        @(negedge clk);
        scan_in = 1'b1;
        @(posedge clk);
        #1;
        eb = sb.pop_front();
        en = sb.pop_front();
        check_pair($sformatf("event kb=%0d kn=%0d", k_b, k_n), eb, en);
        eb.fs = 1'b0;
        en.fs = 1'b0;
        for (int c = 0; c < hold; c++) begin
            @(posedge clk);
            #1;
            check("held-high b.an", {24'h0, b_an}, {24'h0, eb.an});
            check("held-high n.an", {24'h0, n_an}, {24'h0, en.an});
            check("held-high b.fs", {31'h0, b_fs}, 32'h0);
            check("held-high n.fs", {31'h0, n_fs}, 32'h0);
        end
        @(negedge clk);
        scan_in = 1'b0;
        @(posedge clk);
        #1;
        check_pair("after-fall hold", eb, en);
        k_b = (k_b + 1) % 16;
        k_n = (k_n + 1) % 8;
    endtask

    task automatic apply_inputs(input vec_t v);
        @(negedge clk);
        value    = v.value;
        digit_en = v.en;
        dp_in    = v.dpi;
        lz_en    = v.lz;
        cur_vis  = v.vis;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        hex_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        //          value          en     dp     lz    visible digits
        vecs[0] = '{32'h89ABCDEF, 8'hFF, 8'h00, 1'b0, 8'hFF};
        vecs[1] = '{32'h00000120, 8'hFF, 8'h00, 1'b1, 8'h07};
        vecs[2] = '{32'h00000000, 8'hFF, 8'h00, 1'b1, 8'h01};
        vecs[3] = '{32'h00000120, 8'hFF, 8'h20, 1'b1, 8'h3F};
        vecs[4] = '{32'h12345678, 8'h0F, 8'h00, 1'b0, 8'h0F};
        vecs[5] = '{32'h00F00000, 8'hDF, 8'h00, 1'b1, 8'h01};
        vecs[6] = '{32'h0000A003, 8'h5A, 8'h81, 1'b1, 8'h0A};

        reset = 1'b1; scan_in = 1'b0;
        value = 32'hDEADBEEF; digit_en = 8'hFF; dp_in = 8'hFF; lz_en = 1'b1; cur_vis = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        check("reset b.an",  {24'h0, b_an},  32'hFF);
        check("reset b.seg", {25'h0, b_seg}, 32'h7F);
        check("reset b.dp",  {31'h0, b_dp},  32'h1);
        check("reset b.fs",  {31'h0, b_fs},  32'h0);
        check("reset n.an",  {24'h0, n_an},  32'hFF);
        check("reset n.fs",  {31'h0, n_fs},  32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int r = 0; r < 7; r++) begin
            apply_inputs(vecs[r]);
            for (int e = 0; e < 16; e++) do_event(0);
        end

        // Mid-frame value change only lands at the next frame start.
        v = '{32'h11111111, 8'hFF, 8'h00, 1'b0, 8'hFF};
        apply_inputs(v);
        for (int e = 0; e < 5; e++) do_event(0);
        @(negedge clk);
        value = 32'h22222222;
        for (int e = 0; e < 11; e++) do_event(0);
        for (int e = 0; e < 16; e++) do_event(0);

        // scan_in held high for 100 cycles generates exactly one event.
        v = '{32'h0BADF00D, 8'hFF, 8'h0F, 1'b0, 8'hFF};
        apply_inputs(v);
        for (int e = 0; e < 16; e++) do_event((e == 3) ? 100 : 0);

        // Reset in SHOW with idx=5 on the blanking instance.
        for (int e = 0; e < 11; e++) do_event(0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset b.an",  {24'h0, b_an},  32'hFF);
        check("midreset b.seg", {25'h0, b_seg}, 32'h7F);
        check("midreset b.dp",  {31'h0, b_dp},  32'h1);
        check("midreset b.fs",  {31'h0, b_fs},  32'h0);
        check("midreset n.an",  {24'h0, n_an},  32'hFF);
        check("midreset n.seg", {25'h0, n_seg}, 32'h7F);
        @(negedge clk);
        reset = 1'b0;
        k_b = 0;
        k_n = 0;
        v = '{32'h00000120, 8'hFF, 8'h00, 1'b1, 8'h07};
        apply_inputs(v);
        for (int e = 0; e < 16; e++) do_event(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
